// File: rtl/c_fpmul_seq_pkg.sv
// Shared definitions for the sequential FP multiplier: controller states,
// flag bit positions and the exponent bias helper.
package c_fpmul_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BOOTH = 2'd1,
    S_NORM  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

  function automatic int expBias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction

endpackage

// File: rtl/c_booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of the multiplicand
// into the upper half of the accumulator, then an arithmetic shift right.
module c_booth_step #(
  parameter int M = 25
) (
  input  logic [2*M:0] i_acc,
  input  logic [M-1:0] i_mcand,
  input  logic [M-1:0] i_mcand_neg,
  output logic [2*M:0] o_acc
);

  logic [M:0] w_high;
  logic [M:0] w_sum;

  // The sum is kept one bit wider so the shifted-in sign bit is always exact.
  always_comb begin
    w_high = {i_acc[2*M], i_acc[2*M:M+1]};
    case (i_acc[1:0])
      2'b01:   w_sum = w_high + {i_mcand[M-1], i_mcand};
      2'b10:   w_sum = w_high + {i_mcand_neg[M-1], i_mcand_neg};
      default: w_sum = w_high;
    endcase
    o_acc = {w_sum, i_acc[M:1]};
  end

endmodule

// File: rtl/c_fpmul_seq.sv
// Sequential IEEE-754 multiplier: one Booth step per clock, RNE rounding,
// FTZ inputs, special-operand handling and valid/ready on both sides.
module c_fpmul_seq
  import c_fpmul_seq_pkg::*;
#(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [EXP_W+MAN_W:0] i_a,
  input  logic [EXP_W+MAN_W:0] i_b,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [EXP_W+MAN_W:0] o_mul_r,
  output logic [3:0]           o_flags,
  output logic                 o_mul_exception,
  output logic                 o_out_valid,
  input  logic                 i_out_ready
);

  localparam int W   = EXP_W + MAN_W + 1;
  localparam int M   = MAN_W + 2;
  localparam int AW  = 2 * M + 1;
  localparam int PW  = 2 * (MAN_W + 1);
  localparam int EW2 = EXP_W + 2;
  localparam int CW  = $clog2(M);
  localparam logic [EW2-1:0] BIAS = EW2'(expBias(EXP_W));
  localparam logic [EW2-1:0] EMAX = EW2'((1 << EXP_W) - 1);
  localparam logic [W-1:0]   QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [AW-1:0]   r_acc;
  logic [M-1:0]    r_mcand;
  logic [EW2-1:0]  r_exp;
  logic            r_sign;
  logic            r_special;
  logic            r_inReady;
  logic            r_outValid;
  logic [W-1:0]    r_mulR;
  logic [3:0]      r_flags;
  logic            r_exc;

  logic [EXP_W-1:0] w_expA, w_expB;
  logic [MAN_W-1:0] w_fracA, w_fracB;
  logic w_sign, w_zeroA, w_zeroB, w_infA, w_infB, w_nanA, w_nanB, w_snanA, w_snanB, w_special;
  logic [W-1:0]     w_spResult, w_nrResult;
  logic [3:0]       w_spFlags, w_nrFlags;
  logic [M-1:0]     w_mcandNeg;
  logic [AW-1:0]    w_accNext;
  logic [PW-1:0]    w_prod;
  logic [PW-2:0]    w_norm;
  logic             w_top, w_guard, w_sticky, w_roundUp;
  logic [MAN_W:0]   w_fracRnd;
  logic [EW2-1:0]   w_expFin;

  assign w_sign  = i_a[W-1] ^ i_b[W-1];
  assign w_expA  = i_a[W-2:MAN_W];
  assign w_expB  = i_b[W-2:MAN_W];
  assign w_fracA = i_a[MAN_W-1:0];
  assign w_fracB = i_b[MAN_W-1:0];
  // A zero exponent field covers subnormals too, which are flushed to zero.
  assign w_zeroA = (w_expA == '0);
  assign w_zeroB = (w_expB == '0);
  assign w_infA  = (&w_expA) & ~(|w_fracA);
  assign w_infB  = (&w_expB) & ~(|w_fracB);
  assign w_nanA  = (&w_expA) & (|w_fracA);
  assign w_nanB  = (&w_expB) & (|w_fracB);
  assign w_snanA = w_nanA & ~w_fracA[MAN_W-1];
  assign w_snanB = w_nanB & ~w_fracB[MAN_W-1];
  assign w_special = w_zeroA | w_zeroB | (&w_expA) | (&w_expB);

  always_comb begin
    w_spFlags  = '0;
    w_spResult = {w_sign, {(W-1){1'b0}}};
    if (w_nanA | w_nanB) begin
      w_spResult = QNAN;
      w_spFlags[FLAG_INVALID] = w_snanA | w_snanB;
    end else if ((w_zeroA & w_infB) | (w_infA & w_zeroB)) begin
      w_spResult = QNAN;
      w_spFlags[FLAG_INVALID] = 1'b1;
    end else if (w_infA | w_infB) begin
      w_spResult = {w_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  assign w_mcandNeg = -r_mcand;

  c_booth_step #(.M(M)) u_booth (
    .i_acc       (r_acc),
    .i_mcand     (r_mcand),
    .i_mcand_neg (w_mcandNeg),
    .o_acc       (w_accNext)
  );

  // The hidden bit is dropped here; the remaining bits are fraction then guard/sticky.
  assign w_prod    = r_acc[PW:1];
  assign w_top     = w_prod[PW-1];
  assign w_norm    = w_top ? w_prod[PW-2:0] : {w_prod[PW-3:0], 1'b0};
  assign w_guard   = w_norm[MAN_W];
  assign w_sticky  = |w_norm[MAN_W-1:0];
  assign w_roundUp = w_guard & (w_sticky | w_norm[MAN_W+1]);
  assign w_fracRnd = {1'b0, w_norm[PW-2:MAN_W+1]} + (MAN_W+1)'(w_roundUp);
  assign w_expFin  = r_exp + EW2'(w_top) + EW2'(w_fracRnd[MAN_W]);

  always_comb begin
    w_nrFlags = '0;
    w_nrFlags[FLAG_INEXACT] = w_guard | w_sticky;
    w_nrResult = {r_sign, w_expFin[EXP_W-1:0], w_fracRnd[MAN_W-1:0]};
    if (!w_expFin[EW2-1] && (w_expFin >= EMAX)) begin
      w_nrResult = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      w_nrFlags[FLAG_OVERFLOW] = 1'b1;
      w_nrFlags[FLAG_INEXACT]  = 1'b1;
    end else if (w_expFin[EW2-1] || (w_expFin == '0)) begin
      w_nrResult = {r_sign, {(W-1){1'b0}}};
      w_nrFlags[FLAG_UNDERFLOW] = 1'b1;
      w_nrFlags[FLAG_INEXACT]   = 1'b1;
    end
  end

  // Special operands pass through NORM with their result already latched.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_mcand    <= '0;
      r_exp      <= '0;
      r_sign     <= 1'b0;
      r_special  <= 1'b0;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_mulR     <= '0;
      r_flags    <= '0;
      r_exc      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_in_valid) begin
            r_inReady <= 1'b0;
            r_sign    <= w_sign;
            r_cnt     <= '0;
            r_special <= w_special;
            if (w_special) begin
              r_mulR  <= w_spResult;
              r_flags <= w_spFlags;
              r_exc   <= |w_spFlags;
              r_state <= S_NORM;
            end else begin
              r_mcand <= {2'b01, w_fracA};
              r_acc   <= {{M{1'b0}}, 2'b01, w_fracB, 1'b0};
              r_exp   <= {2'b00, w_expA} + {2'b00, w_expB} - BIAS;
              r_state <= S_BOOTH;
            end
          end
        end
        S_BOOTH: begin
          r_acc <= w_accNext;
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(M - 1)) r_state <= S_NORM;
        end
        S_NORM: begin
          if (!r_special) begin
            r_mulR  <= w_nrResult;
            r_flags <= w_nrFlags;
            r_exc   <= |w_nrFlags;
          end
          r_outValid <= 1'b1;
          r_state    <= S_DONE;
        end
        S_DONE: begin
          if (i_out_ready) begin
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_in_ready      = r_inReady;
  assign o_out_valid     = r_outValid;
  assign o_mul_r         = r_mulR;
  assign o_flags         = r_flags;
  assign o_mul_exception = r_exc;

endmodule

// File: tb/tb_c_fpmul_seq.sv
// Self-checking bench for c_fpmul_seq: directed vectors, randomized operands
// against an arithmetic reference model, stall and mid-operation reset.
module tb_c_fpmul_seq;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] aIn, bIn, mulR;
  logic        inValid, inReady, outValid, outReady, mulExc;
  logic [3:0]  flags;

  logic [63:0] a64, b64, mulR64;
  logic        inValid64, inReady64, outValid64, outReady64, mulExc64;
  logic [3:0]  flags64;

  int checkCount = 0;
  int errorCount = 0;

  c_fpmul_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .i_clk(clk), .i_reset(reset), .i_a(aIn), .i_b(bIn),
    .i_in_valid(inValid), .o_in_ready(inReady), .o_mul_r(mulR),
    .o_flags(flags), .o_mul_exception(mulExc), .o_out_valid(outValid),
    .i_out_ready(outReady)
  );

  c_fpmul_seq #(.EXP_W(11), .MAN_W(52)) dut64 (
    .i_clk(clk), .i_reset(reset), .i_a(a64), .i_b(b64),
    .i_in_valid(inValid64), .o_in_ready(inReady64), .o_mul_r(mulR64),
    .o_flags(flags64), .o_mul_exception(mulExc64), .o_out_valid(outValid64),
    .i_out_ready(outReady64)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checkCount++;
    if (got !== want) begin
      errorCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, want);
    end
  endtask

  // Reference multiply computed with wide integer arithmetic and explicit
  // half-ulp comparison for round-to-nearest-even.
  function automatic void refMul(input int ew, input int mw, input logic [63:0] x,
                                 input logic [63:0] y, output logic [63:0] r,
                                 output logic [3:0] f);
    int emax, bias, ex, ey, e, sh;
    logic [63:0] fracMask, fx, fy, qnan, signBit;
    logic [127:0] prod, mant, rem, half;
    logic xNan, yNan, xInf, yInf, xZero, yZero;
    emax = (1 << ew) - 1;
    bias = (1 << (ew - 1)) - 1;
    fracMask = (64'd1 << mw) - 64'd1;
    ex = int'((x >> mw) & 64'(emax));
    ey = int'((y >> mw) & 64'(emax));
    fx = x & fracMask;
    fy = y & fracMask;
    signBit = 64'(x[ew+mw] ^ y[ew+mw]) << (ew + mw);
    qnan = (64'(emax) << mw) | (64'd1 << (mw - 1));
    xNan = (ex == emax) && (fx != 0);
    yNan = (ey == emax) && (fy != 0);
    xInf = (ex == emax) && (fx == 0);
    yInf = (ey == emax) && (fy == 0);
    xZero = (ex == 0);
    yZero = (ey == 0);
    f = '0;
    r = '0;
    if (xNan || yNan) begin
      r = qnan;
      f[3] = (xNan && !fx[mw-1]) || (yNan && !fy[mw-1]);
    end else if ((xZero && yInf) || (xInf && yZero)) begin
      r = qnan;
      f[3] = 1'b1;
    end else if (xInf || yInf) begin
      r = signBit | (64'(emax) << mw);
    end else if (xZero || yZero) begin
      r = signBit;
    end else begin
      prod = (128'(fx) | (128'd1 << mw)) * (128'(fy) | (128'd1 << mw));
      e = ex + ey - bias;
      sh = mw;
      if ((prod >> (2 * mw + 1)) != 0) begin
        sh = mw + 1;
        e++;
      end
      mant = prod >> sh;
      rem  = prod & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      if (rem > half || (rem == half && mant[0])) mant = mant + 128'd1;
      if ((mant >> (mw + 1)) != 0) begin
        mant = mant >> 1;
        e++;
      end
      if (e >= emax) begin
        r = signBit | (64'(emax) << mw);
        f = 4'b0101;
      end else if (e <= 0) begin
        r = signBit;
        f = 4'b0011;
      end else begin
        r = signBit | (64'(e) << mw) | (mant[63:0] & fracMask);
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [63:0] randOp(input int ew, input int mw, input int mode);
    logic [63:0] v;
    int bias, emax, e;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    v = {$urandom, $urandom};
    v = v & ((64'd1 << (ew + mw + 1)) - 64'd1);
    if (mode == 7)      e = emax - 1 - int'($urandom_range(0, 40));
    else if (mode == 8) e = 1 + int'($urandom_range(0, 30));
    else if (mode == 9) e = ($urandom_range(0, 1) == 1) ? emax : 0;
    else                e = bias - 27 + int'($urandom_range(0, 54));
    v = (v & ~(64'(emax) << mw)) | (64'(e) << mw);
    if (mode == 9 && $urandom_range(0, 1) == 1) v = v & ~((64'd1 << mw) - 64'd1);
    return v;
  endfunction

  function automatic bit isSpecial(input int ew, input int mw, input logic [63:0] v);
    int emax, e;
    emax = (1 << ew) - 1;
    e = int'((v >> mw) & 64'(emax));
    return (e == 0) || (e == emax);
  endfunction

  task automatic applyStimulus(input logic [31:0] opA, input logic [31:0] opB,
                               output logic [31:0] res, output logic [3:0] flg,
                               output logic exc, output int lat);
    int guard = 0;
    @(negedge clk);
    while (!inReady && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    aIn = opA;
    bIn = opB;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    res = mulR;
    flg = flags;
    exc = mulExc;
    @(negedge clk) outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
  endtask

  task automatic applyStimulus64(input logic [63:0] opA, input logic [63:0] opB,
                                 output logic [63:0] res, output logic [3:0] flg,
                                 output int lat);
    int guard = 0;
    @(negedge clk);
    while (!inReady64 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    a64 = opA;
    b64 = opB;
    inValid64 = 1'b1;
    @(posedge clk);
    #1 inValid64 = 1'b0;
    lat = 0;
    while (!outValid64 && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    res = mulR64;
    flg = flags64;
    @(negedge clk) outReady64 = 1'b1;
    @(posedge clk);
    #1 outReady64 = 1'b0;
  endtask

  task automatic runDirected(input string tag, input logic [31:0] opA, input logic [31:0] opB,
                             input logic [31:0] expRes, input logic [3:0] expFlg, input int expLat);
    logic [31:0] res;
    logic [3:0]  flg;
    logic        exc;
    int          lat;
    applyStimulus(opA, opB, res, flg, exc, lat);
    checkOutput({tag, ".res"}, 64'(res), 64'(expRes));
    checkOutput({tag, ".flags"}, 64'(flg), 64'(expFlg));
    checkOutput({tag, ".exc"}, 64'(exc), 64'(|expFlg));
    checkOutput({tag, ".lat"}, 64'(lat), 64'(expLat));
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [31:0] res;
    logic [3:0]  flg;
    logic        exc;
    int          lat;
    logic [63:0] opA, opB, expR, res64;
    logic [3:0]  expF;
    int          modeA, modeB;

    inValid = 0; outReady = 0; aIn = '0; bIn = '0;
    inValid64 = 0; outReady64 = 0; a64 = '0; b64 = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.inReady", 64'(inReady), 64'd1);
    checkOutput("reset.outValid", 64'(outValid), 64'd0);
    checkOutput("reset.mulR", 64'(mulR), 64'd0);
    checkOutput("reset.flags", 64'(flags), 64'd0);
    checkOutput("reset.exc", 64'(mulExc), 64'd0);
    @(negedge clk) reset = 1'b1;

    runDirected("d.1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);
    runDirected("d.rne", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26);
    runDirected("d.neg", 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'b0000, 26);
    runDirected("d.ovf", 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'b0101, 26);
    runDirected("d.unf", 32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 26);
    runDirected("d.zeroInf", 32'h00000000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1);
    runDirected("d.qnan", 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0000, 1);
    runDirected("d.snan", 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    runDirected("d.infFin", 32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1);
    runDirected("d.zeroFin", 32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1);
    runDirected("d.ftz", 32'h00000001, 32'hBF800000, 32'h80000000, 4'b0000, 1);

    for (int i = 0; i < 40; i++) begin
      modeA = int'($urandom_range(0, 9));
      modeB = int'($urandom_range(0, 9));
      opA = randOp(8, 23, modeA);
      opB = randOp(8, 23, modeB);
      refMul(8, 23, opA, opB, expR, expF);
      applyStimulus(opA[31:0], opB[31:0], res, flg, exc, lat);
      checkOutput($sformatf("r%0d.res a=%h b=%h", i, opA[31:0], opB[31:0]), 64'(res), expR);
      checkOutput($sformatf("r%0d.flags", i), 64'(flg), 64'(expF));
      checkOutput($sformatf("r%0d.exc", i), 64'(exc), 64'(|expF));
      checkOutput($sformatf("r%0d.lat", i), 64'(lat),
                  (isSpecial(8, 23, opA) || isSpecial(8, 23, opB)) ? 64'd1 : 64'd26);
    end

    // Output stall: result held, new operands ignored while busy.
    @(negedge clk);
    aIn = 32'h3FC00000;
    bIn = 32'h40000000;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    lat = 0;
    while (!outValid && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    checkOutput("stall.lat", 64'(lat), 64'd26);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      aIn = $urandom;
      bIn = $urandom;
      inValid = i[0];
      @(posedge clk);
      #1;
      checkOutput($sformatf("stall%0d.outValid", i), 64'(outValid), 64'd1);
      checkOutput($sformatf("stall%0d.mulR", i), 64'(mulR), 64'h40400000);
      checkOutput($sformatf("stall%0d.inReady", i), 64'(inReady), 64'd0);
    end
    @(negedge clk);
    inValid = 1'b0;
    outReady = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b0;
    checkOutput("release.inReady", 64'(inReady), 64'd1);
    checkOutput("release.outValid", 64'(outValid), 64'd0);
    runDirected("release.next", 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 26);

    // Reset partway through the Booth sequence.
    @(negedge clk);
    aIn = 32'h40400000;
    bIn = 32'h40400000;
    inValid = 1'b1;
    @(posedge clk);
    #1 inValid = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midReset.inReady", 64'(inReady), 64'd1);
    checkOutput("midReset.outValid", 64'(outValid), 64'd0);
    @(negedge clk) reset = 1'b1;
    repeat (30) @(posedge clk);
    #1 checkOutput("midReset.discarded", 64'(outValid), 64'd0);
    runDirected("midReset.after", 32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 26);

    // Double-precision instance.
    applyStimulus64(64'h3FF8000000000000, 64'h4000000000000000, res64, flg, lat);
    checkOutput("dp.res", res64, 64'h4008000000000000);
    checkOutput("dp.flags", 64'(flg), 64'd0);
    checkOutput("dp.lat", 64'(lat), 64'd55);
    for (int i = 0; i < 12; i++) begin
      modeA = int'($urandom_range(0, 9));
      modeB = int'($urandom_range(0, 9));
      opA = randOp(11, 52, modeA);
      opB = randOp(11, 52, modeB);
      refMul(11, 52, opA, opB, expR, expF);
      applyStimulus64(opA, opB, res64, flg, lat);
      checkOutput($sformatf("dp%0d.res a=%h b=%h", i, opA, opB), res64, expR);
      checkOutput($sformatf("dp%0d.flags", i), 64'(flg), 64'(expF));
      checkOutput($sformatf("dp%0d.lat", i), 64'(lat),
                  (isSpecial(11, 52, opA) || isSpecial(11, 52, opB)) ? 64'd1 : 64'd55);
    end

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
